binary_multiplier_4x3: RTL and testbench

- Unsigned 4-bit by 3-bit array multiplier producing a 7-bit product.
- Internally an AND-gate partial-product array reduced by two ripple rows of half/full adders.
- The product is registered once at the output, giving a single-cycle-latency arithmetic leaf for datapaths needing small constant/operand scaling.

---
 rtl/binary_multiplier_4x3.sv | 113 +++++++++++
 tb/tb_binary_multiplier_4x3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/binary_multiplier_4x3.sv
// Unsigned 4x3 array multiplier: AND partial products reduced by two ripple
// rows of half/full adder cells, product registered once at the output.

module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshake: valid-only, no backpressure. in_valid high at a rising edge
// captures C*D into M and raises out_valid for exactly the following cycle;
// in_valid low keeps M and drops out_valid.
module binary_multiplier_4x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] C,
    input  logic [2:0] D,
    output logic [6:0] M,
    output logic       out_valid
);
    logic [3:0] pp [0:2];
    logic [3:0] row1_a;
    logic [3:0] row1_s;
    logic [4:1] row1_c;
    logic [4:0] row1;
    logic [3:0] row2_a;
    logic [3:0] row2_s;
    logic [4:1] row2_c;
    logic [6:0] product;

    genvar i, j;
    generate
        for (j = 0; j < 3; j++) begin : g_pp
            assign pp[j] = C & {4{D[j]}};
        end
    endgenerate

    // Row 1: pp[0] shifted down by one against pp[1]; top slot of pp[0] is empty.
    assign row1_a = {1'b0, pp[0][3:1]};

    ha_cell u_r1_ha (
        .a  (row1_a[0]),
        .b  (pp[1][0]),
        .s  (row1_s[0]),
        .co (row1_c[1])
    );

    generate
        for (i = 1; i < 4; i++) begin : g_row1
            fa_cell u_fa (
                .a  (row1_a[i]),
                .b  (pp[1][i]),
                .ci (row1_c[i]),
                .s  (row1_s[i]),
                .co (row1_c[i+1])
            );
        end
    endgenerate

    assign row1 = {row1_c[4], row1_s};

    // Row 2: row-1 bits above its LSB against pp[2].
    assign row2_a = row1[4:1];

    ha_cell u_r2_ha (
        .a  (row2_a[0]),
        .b  (pp[2][0]),
        .s  (row2_s[0]),
        .co (row2_c[1])
    );

    generate
        for (i = 1; i < 4; i++) begin : g_row2
            fa_cell u_fa (
                .a  (row2_a[i]),
                .b  (pp[2][i]),
                .ci (row2_c[i]),
                .s  (row2_s[i]),
                .co (row2_c[i+1])
            );
        end
    endgenerate

    assign product = {row2_c[4], row2_s, row1[0], pp[0][0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M         <= 7'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                M <= product;
            end
        end
    end
endmodule

// File: tb/tb_binary_multiplier_4x3.sv
// Bench for binary_multiplier_4x3: directed vectors with literal expectations
// plus an arithmetic reference model compared on every falling edge.

module tb_binary_multiplier_4x3;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] C;
    logic [2:0] D;
    logic [6:0] M;
    logic       out_valid;

    int vectors;
    int miscompares;
    logic check_en;

    logic [6:0] exp_m;
    logic       exp_v;
    logic [6:0] exp_q[$];

    binary_multiplier_4x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .C         (C),
        .D         (D),
        .M         (M),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: registered product of the unsigned operands
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_m <= 7'd0;
            exp_v <= 1'b0;
        end else begin
            exp_v <= in_valid;
            if (in_valid) begin
                exp_m <= {3'b000, C} * {4'b0000, D};
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            vectors++;
            if (M !== exp_m || out_valid !== exp_v) begin
                miscompares++;
                $display("FAIL model_cycle @%0t: M=%0d out_valid=%0b, expected M=%0d out_valid=%0b",
                         $time, M, out_valid, exp_m, exp_v);
            end
        end
    end

    // driver: present operands, wait for the capturing edge, settle 1 ns
    task automatic step(input logic [3:0] c, input logic [2:0] d, input logic v);
        C = c;
        D = d;
        in_valid = v;
        if (v) exp_q.push_back({3'b000, c} * {4'b0000, d});
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] em, input logic ev);
        vectors++;
        if (M !== em || out_valid !== ev) begin
            miscompares++;
            $display("FAIL %s: M=%0d out_valid=%0b, expected M=%0d out_valid=%0b",
                     name, M, out_valid, em, ev);
        end
    endtask

    // scoreboard pop: compare against the queued arithmetic product
    task automatic check_q(input string name);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: expected queue empty, M=%0d", name, M);
        end else begin
            e = exp_q.pop_front();
            check(name, e, 1'b1);
        end
    endtask

    int dir_c [7] = '{0, 1, 6, 10, 15, 13, 15};
    int dir_d [7] = '{0, 3, 7, 5, 3, 2, 7};
    int dir_m [7] = '{0, 3, 42, 50, 45, 26, 105};
    int cc_c  [4] = '{15, 15, 15, 8};
    int cc_d  [4] = '{1, 2, 4, 7};
    int cc_m  [4] = '{15, 30, 60, 56};

    initial begin
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        C           = 4'd0;
        D           = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 7'd0, 1'b0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // directed vectors, hand-computed products
        for (int k = 0; k < 7; k++) begin
            step(4'(dir_c[k]), 3'(dir_d[k]), 1'b1);
            check($sformatf("directed_%0dx%0d", dir_c[k], dir_d[k]), 7'(dir_m[k]), 1'b1);
            void'(exp_q.pop_front());
        end

        // asynchronous reset mid-cycle with M=105
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", 7'd0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step(4'd15, 3'd7, 1'b0);
        check("post_reset_idle", 7'd0, 1'b0);

        // hold
        step(4'd6, 3'd7, 1'b1);
        check("hold_capture", 7'd42, 1'b1);
        void'(exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            step(4'd15, 3'd7, 1'b0);
            check($sformatf("hold_%0d", k), 7'd42, 1'b0);
        end

        // carry chain
        for (int k = 0; k < 4; k++) begin
            step(4'(cc_c[k]), 3'(cc_d[k]), 1'b1);
            check($sformatf("carry_%0dx%0d", cc_c[k], cc_d[k]), 7'(cc_m[k]), 1'b1);
            void'(exp_q.pop_front());
        end

        // exhaustive, back-to-back
        for (int c = 0; c < 16; c++) begin
            for (int d = 0; d < 8; d++) begin
                step(4'(c), 3'(d), 1'b1);
                check_q($sformatf("exh_%0dx%0d", c, d));
            end
        end

        // reset during a stream
        step(4'd3, 3'd5, 1'b1);
        check_q("stream_a");
        C = 4'd9;
        D = 3'd7;
        #2 rst_n = 1'b0;
        #1;
        check("stream_reset", 7'd0, 1'b0);
        #2 rst_n = 1'b1;
        step(4'd10, 3'd5, 1'b1);
        check("stream_after_reset", 7'd50, 1'b1);
        void'(exp_q.pop_front());
        step(4'd0, 3'd0, 1'b0);
        check("stream_tail_hold", 7'd50, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
